even_fwd_pipe: RTL

- Sits directly downstream of the even-pipe simple-fixed execution unit. Consumes its 139-bit result packets: data[0:127], lat[128:130], wr_en[131], rt[132:138].
- Carries each packet through a DEPTH-stage result shift pipe until it reaches register-file writeback.
- Gives three register-read ports combinational forwarding from in-flight packets, plus a hazard request for operands that are in flight but not yet ready.

---
 rtl/even_fwd_pipe_if.sv | 32 +++
 rtl/even_fwd_pipe.sv | 87 ++++++++
 2 files changed

// File: rtl/even_fwd_pipe_if.sv
// Bus bundle for the even-pipe result/forwarding pipe: execution-unit input, register-read
// lookups, forwarding results and register-file writeback.
interface even_fwd_pipe_if;
    logic         flush;
    logic [138:0] in_data;
    logic [6:0]   rd_addr_a;
    logic [6:0]   rd_addr_b;
    logic [6:0]   rd_addr_c;
    logic         fwd_hit_a;
    logic         fwd_hit_b;
    logic         fwd_hit_c;
    logic [127:0] fwd_data_a;
    logic [127:0] fwd_data_b;
    logic [127:0] fwd_data_c;
    logic         hazard;
    logic         wb_en;
    logic [6:0]   wb_addr;
    logic [127:0] wb_data;
    logic [2:0]   occupancy;

    modport master (
        output flush, in_data, rd_addr_a, rd_addr_b, rd_addr_c,
        input  fwd_hit_a, fwd_hit_b, fwd_hit_c, fwd_data_a, fwd_data_b, fwd_data_c,
        input  hazard, wb_en, wb_addr, wb_data, occupancy
    );

    modport slave (
        input  flush, in_data, rd_addr_a, rd_addr_b, rd_addr_c,
        output fwd_hit_a, fwd_hit_b, fwd_hit_c, fwd_data_a, fwd_data_b, fwd_data_c,
        output hazard, wb_en, wb_addr, wb_data, occupancy
    );
endinterface

// File: rtl/even_fwd_pipe.sv
// Result shift pipe behind the even-pipe simple-fixed unit: carries packets to writeback and
// forwards ready in-flight results to three register-read ports.
module even_fwd_pipe #(
    parameter int unsigned DEPTH        = 6,
    parameter int unsigned FLUSH_STAGES = 2
) (
    input logic            clk,
    input logic            reset,
    even_fwd_pipe_if.slave bus
);
    // Packet layout: [127:0] data, [130:128] lat, [131] wr_en, [138:132] rt
    logic [138:0] stage_q [1:DEPTH];
    logic [138:0] stage_d [1:DEPTH];
    logic [2:0]   occ_d;
    logic [2:0]   occ_q;
    logic         wb_en_q;
    logic [6:0]   wb_addr_q;
    logic [127:0] wb_data_q;

    logic [6:0]   lk_addr [3];
    logic         lk_hit  [3];
    logic [127:0] lk_data [3];
    logic         lk_haz  [3];

    always_comb begin
        stage_d[1] = bus.flush ? '0 : bus.in_data;
        occ_d      = {2'b0, stage_d[1][131]};
        for (int unsigned k = 2; k <= DEPTH; k++) begin
            stage_d[k] = (bus.flush && k <= FLUSH_STAGES) ? '0 : stage_q[k-1];
            occ_d      = occ_d + {2'b0, stage_d[k][131]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q   <= '{default: '0};
            occ_q     <= '0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            stage_q   <= stage_d;
            occ_q     <= occ_d;
            wb_en_q   <= stage_q[DEPTH][131];
            wb_addr_q <= stage_q[DEPTH][131] ? stage_q[DEPTH][138:132] : '0;
            wb_data_q <= stage_q[DEPTH][131] ? stage_q[DEPTH][127:0] : '0;
        end
    end

    assign lk_addr[0] = bus.rd_addr_a;
    assign lk_addr[1] = bus.rd_addr_b;
    assign lk_addr[2] = bus.rd_addr_c;

    always_comb begin
        for (int p = 0; p < 3; p++) begin
            lk_hit[p]  = 1'b0;
            lk_data[p] = '0;
            lk_haz[p]  = 1'b0;
            // Oldest to youngest, so the youngest match is the one left standing
            for (int k = int'(DEPTH); k >= 1; k--) begin
                if (stage_q[k][131] && stage_q[k][138:132] == lk_addr[p]) begin
                    if (stage_q[k][130:128] == 3'd0 || k >= int'(stage_q[k][130:128])) begin
                        lk_hit[p]  = 1'b1;
                        lk_data[p] = stage_q[k][127:0];
                        lk_haz[p]  = 1'b0;
                    end else begin
                        lk_hit[p]  = 1'b0;
                        lk_data[p] = '0;
                        lk_haz[p]  = 1'b1;
                    end
                end
            end
        end
    end

    assign bus.fwd_hit_a  = lk_hit[0];
    assign bus.fwd_hit_b  = lk_hit[1];
    assign bus.fwd_hit_c  = lk_hit[2];
    assign bus.fwd_data_a = lk_data[0];
    assign bus.fwd_data_b = lk_data[1];
    assign bus.fwd_data_c = lk_data[2];
    assign bus.hazard     = lk_haz[0] | lk_haz[1] | lk_haz[2];
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_addr    = wb_addr_q;
    assign bus.wb_data    = wb_data_q;
    assign bus.occupancy  = occ_q;
endmodule
